// File: rtl/rs_age_queue_pkg.sv
// Shared constants and CDB packing helpers for the age-ordered reservation station.
package rs_age_queue_pkg;

  localparam int RS_TYPE_WIDTH = 5;
  localparam int RS_ROB_WIDTH  = 4;
  localparam int DATA_W        = 32;

  // LSB position of bus `bus` inside a packed CDB vector whose per-bus field is `width` bits.
  function automatic int cdb_lsb(input int bus, input int width);
    return bus * width;
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready selector: grants the ready entry that has no older ready entry.
module rs_age_select
  import rs_age_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] ready_i,
  input  logic [DEPTH-1:0] older_i [DEPTH],
  output logic [DEPTH-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  // Entry i wins when it is ready and none of the entries it considers older are ready.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    grant_o     = '0;
    grant_idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_o[i] = ready_i[i] && ((older_i[i] & ready_i) == '0);
      if (grant_o[i]) grant_idx_o = grant_idx_o | IDX_W'(i);
    end
  end

endmodule

// File: rtl/rs_age_queue.sv
// Reservation station with CDB wakeup/bypass and oldest-ready issue to a single FU.
module rs_age_queue
  import rs_age_queue_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ROB_WIDTH  = RS_ROB_WIDTH,
  parameter int TYPE_WIDTH = RS_TYPE_WIDTH,
  parameter int NUM_CDB    = 2,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           flush,
  input  logic                           dec_valid,
  output logic                           dec_full,
  input  logic [TYPE_WIDTH-1:0]          dec_type,
  input  logic [DATA_W-1:0]              dec_data_j,
  input  logic [DATA_W-1:0]              dec_data_k,
  input  logic                           dec_pending_j,
  input  logic                           dec_pending_k,
  input  logic [ROB_WIDTH-1:0]           dec_dep_j,
  input  logic [ROB_WIDTH-1:0]           dec_dep_k,
  input  logic [ROB_WIDTH-1:0]           dec_rob_id,
  input  logic [DATA_W-1:0]              dec_imm,
  input  logic [NUM_CDB-1:0]             cdb_valid,
  input  logic [NUM_CDB*ROB_WIDTH-1:0]   cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]      cdb_data,
  output logic                           issue_valid,
  input  logic                           fu_ready,
  output logic [TYPE_WIDTH-1:0]          issue_type,
  output logic [DATA_W-1:0]              issue_data_j,
  output logic [DATA_W-1:0]              issue_data_k,
  output logic [DATA_W-1:0]              issue_imm,
  output logic [ROB_WIDTH-1:0]           issue_rob_id,
  output logic [IDX_W:0]                 count
);

  localparam logic [IDX_W:0] CNT_FULL = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W + 1)'(1);

  logic [DEPTH-1:0]      present_q, present_d;
  logic [DEPTH-1:0]      pend_j_q, pend_j_d, pend_k_q, pend_k_d;
  logic [DEPTH-1:0]      older_q [DEPTH];
  logic [DEPTH-1:0]      older_d [DEPTH];
  logic [TYPE_WIDTH-1:0] type_q [DEPTH];
  logic [TYPE_WIDTH-1:0] type_d [DEPTH];
  logic [DATA_W-1:0]     data_j_q [DEPTH];
  logic [DATA_W-1:0]     data_j_d [DEPTH];
  logic [DATA_W-1:0]     data_k_q [DEPTH];
  logic [DATA_W-1:0]     data_k_d [DEPTH];
  logic [DATA_W-1:0]     imm_q [DEPTH];
  logic [DATA_W-1:0]     imm_d [DEPTH];
  logic [ROB_WIDTH-1:0]  dep_j_q [DEPTH];
  logic [ROB_WIDTH-1:0]  dep_j_d [DEPTH];
  logic [ROB_WIDTH-1:0]  dep_k_q [DEPTH];
  logic [ROB_WIDTH-1:0]  dep_k_d [DEPTH];
  logic [ROB_WIDTH-1:0]  rob_q [DEPTH];
  logic [ROB_WIDTH-1:0]  rob_d [DEPTH];
  logic [IDX_W:0]        count_q, count_d;

  logic [ROB_WIDTH-1:0]  bus_tag  [NUM_CDB];
  logic [DATA_W-1:0]     bus_data [NUM_CDB];
  logic [DEPTH-1:0]      ready, grant;
  logic [IDX_W-1:0]      grant_idx, free_idx;
  logic                  ins, iss;

  for (genvar b = 0; b < NUM_CDB; b++) begin : g_cdb
    assign bus_tag[b]  = cdb_tag[cdb_lsb(b, ROB_WIDTH) +: ROB_WIDTH];
    assign bus_data[b] = cdb_data[cdb_lsb(b, DATA_W) +: DATA_W];
  end

  assign ready       = present_q & ~pend_j_q & ~pend_k_q;
  assign issue_valid = |ready;
  assign dec_full    = (count_q == CNT_FULL);
  assign count       = count_q;
  assign ins         = dec_valid && !dec_full && rdy_in && !flush;
  assign iss         = issue_valid && fu_ready && rdy_in && !flush;

  rs_age_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
    .ready_i     (ready),
    .older_i     (older_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign issue_type   = type_q[grant_idx];
  assign issue_data_j = data_j_q[grant_idx];
  assign issue_data_k = data_k_q[grant_idx];
  assign issue_imm    = imm_q[grant_idx];
  assign issue_rob_id = rob_q[grant_idx];

  // Lowest-index empty slot; its value is only used when not full.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!present_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Next state: flush dominates; otherwise wakeup, issue and insert/bypass all apply.
  always_comb begin
    present_d = present_q;
    pend_j_d  = pend_j_q;
    pend_k_d  = pend_k_q;
    older_d   = older_q;
    type_d    = type_q;
    data_j_d  = data_j_q;
    data_k_d  = data_k_q;
    imm_d     = imm_q;
    dep_j_d   = dep_j_q;
    dep_k_d   = dep_k_q;
    rob_d     = rob_q;
    count_d   = count_q;
    if (flush) begin
      present_d = '0;
      count_d   = '0;
    end else begin
      // Buses scanned high to low so the lowest matching bus wins.
      for (int i = 0; i < DEPTH; i++) begin
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
          if (present_q[i] && cdb_valid[b] && pend_j_q[i] && bus_tag[b] == dep_j_q[i]) begin
            data_j_d[i] = bus_data[b];
            pend_j_d[i] = 1'b0;
          end
          if (present_q[i] && cdb_valid[b] && pend_k_q[i] && bus_tag[b] == dep_k_q[i]) begin
            data_k_d[i] = bus_data[b];
            pend_k_d[i] = 1'b0;
          end
        end
      end
      if (iss) present_d = present_d & ~grant;
      if (ins) begin
        present_d[free_idx] = 1'b1;
        type_d[free_idx]    = dec_type;
        imm_d[free_idx]     = dec_imm;
        rob_d[free_idx]     = dec_rob_id;
        dep_j_d[free_idx]   = dec_dep_j;
        dep_k_d[free_idx]   = dec_dep_k;
        data_j_d[free_idx]  = dec_data_j;
        data_k_d[free_idx]  = dec_data_k;
        pend_j_d[free_idx]  = dec_pending_j;
        pend_k_d[free_idx]  = dec_pending_k;
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
          if (dec_pending_j && cdb_valid[b] && bus_tag[b] == dec_dep_j) begin
            data_j_d[free_idx] = bus_data[b];
            pend_j_d[free_idx] = 1'b0;
          end
          if (dec_pending_k && cdb_valid[b] && bus_tag[b] == dec_dep_k) begin
            data_k_d[free_idx] = bus_data[b];
            pend_k_d[free_idx] = 1'b0;
          end
        end
        // Everything already present is older than the newcomer; nothing is younger yet.
        older_d[free_idx] = present_q;
        for (int i = 0; i < DEPTH; i++) older_d[i][free_idx] = 1'b0;
      end
      if (ins && !iss)      count_d = count_q + CNT_ONE;
      else if (iss && !ins) count_d = count_q - CNT_ONE;
    end
  end

  // State registers: cleared by reset, frozen while rdy_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      // NOTE: payload arrays are reset too, so the issue outputs read zero straight out of reset.
      present_q <= '0;
      pend_j_q  <= '0;
      pend_k_q  <= '0;
      older_q   <= '{default: '0};
      type_q    <= '{default: '0};
      data_j_q  <= '{default: '0};
      data_k_q  <= '{default: '0};
      imm_q     <= '{default: '0};
      dep_j_q   <= '{default: '0};
      dep_k_q   <= '{default: '0};
      rob_q     <= '{default: '0};
      count_q   <= '0;
    end else if (rdy_in) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge next-state values.
      present_q <= present_d;
      pend_j_q  <= pend_j_d;
      pend_k_q  <= pend_k_d;
      older_q   <= older_d;
      type_q    <= type_d;
      data_j_q  <= data_j_d;
      data_k_q  <= data_k_d;
      imm_q     <= imm_d;
      dep_j_q   <= dep_j_d;
      dep_k_q   <= dep_k_d;
      rob_q     <= rob_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_rs_age_queue.sv
// Scoreboard bench: stimulus queues expected issues, a negedge monitor checks each handshake.
module tb_rs_age_queue;

  localparam int DEPTH = 8;
  localparam int RW    = 4;
  localparam int TW    = 5;
  localparam int NC    = 2;
  localparam int IW    = 3;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in, flush, dec_valid, dec_full;
  logic [TW-1:0]     dec_type;
  logic [31:0]       dec_data_j, dec_data_k, dec_imm;
  logic              dec_pending_j, dec_pending_k;
  logic [RW-1:0]     dec_dep_j, dec_dep_k, dec_rob_id;
  logic [NC-1:0]     cdb_valid;
  logic [NC*RW-1:0]  cdb_tag;
  logic [NC*32-1:0]  cdb_data;
  logic              issue_valid, fu_ready;
  logic [TW-1:0]     issue_type;
  logic [31:0]       issue_data_j, issue_data_k, issue_imm;
  logic [RW-1:0]     issue_rob_id;
  logic [IW:0]       count;

  rs_age_queue #(.DEPTH(DEPTH), .ROB_WIDTH(RW), .TYPE_WIDTH(TW), .NUM_CDB(NC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .dec_valid(dec_valid), .dec_full(dec_full), .dec_type(dec_type),
    .dec_data_j(dec_data_j), .dec_data_k(dec_data_k),
    .dec_pending_j(dec_pending_j), .dec_pending_k(dec_pending_k),
    .dec_dep_j(dec_dep_j), .dec_dep_k(dec_dep_k), .dec_rob_id(dec_rob_id),
    .dec_imm(dec_imm), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .fu_ready(fu_ready), .issue_type(issue_type),
    .issue_data_j(issue_data_j), .issue_data_k(issue_data_k), .issue_imm(issue_imm),
    .issue_rob_id(issue_rob_id), .count(count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [RW-1:0] rob;
    logic [TW-1:0] typ;
    logic [31:0]   dj;
    logic [31:0]   dk;
    logic [31:0]   imm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  function automatic exp_t mk_ready(input logic [RW-1:0] rob);
    exp_t e;
    e.rob = rob;
    e.typ = TW'(rob) + 5'd1;
    e.dj  = 32'h1000 + 32'(rob);
    e.dk  = 32'h2000 + 32'(rob);
    e.imm = 32'h3000 + 32'(rob);
    return e;
  endfunction

  task automatic set_dec(input exp_t e, input logic pj, input logic pk,
                         input logic [RW-1:0] depj, input logic [RW-1:0] depk);
    dec_rob_id    = e.rob;
    dec_type      = e.typ;
    dec_data_j    = e.dj;
    dec_data_k    = e.dk;
    dec_imm       = e.imm;
    dec_pending_j = pj;
    dec_pending_k = pk;
    dec_dep_j     = depj;
    dec_dep_k     = depk;
    dec_valid     = 1'b1;
  endtask

  // Insert a ready op; `expect_it` queues it on the scoreboard.
  task automatic insert_ready(input logic [RW-1:0] rob, input bit expect_it);
    set_dec(mk_ready(rob), 1'b0, 1'b0, '0, '0);
    tick();
    dec_valid = 1'b0;
    if (expect_it) exp_q.push_back(mk_ready(rob));
  endtask

  // Monitor: every completed handshake must match the head of the scoreboard.
  always @(negedge clk_in) begin
    if (!rst_in && rdy_in && !flush && issue_valid && fu_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual_rob=%0d expected=none", issue_rob_id);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_rob_id", 32'(issue_rob_id), 32'(mon_e.rob));
        check("issue_type",   32'(issue_type),   32'(mon_e.typ));
        check("issue_data_j", issue_data_j,      mon_e.dj);
        check("issue_data_k", issue_data_k,      mon_e.dk);
        check("issue_imm",    issue_imm,         mon_e.imm);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; fu_ready = 1'b0;
    dec_valid = 1'b0; dec_type = '0; dec_data_j = '0; dec_data_k = '0; dec_imm = '0;
    dec_pending_j = 1'b0; dec_pending_k = 1'b0; dec_dep_j = '0; dec_dep_k = '0; dec_rob_id = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;

    // Reset then idle.
    tick(); tick();
    rst_in = 1'b0;
    tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(dec_full), 32'd0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_rob_id", 32'(issue_rob_id), 32'd0);
    check("rst_data_j", issue_data_j, 32'd0);

    // Age order: 3, 1, 5.
    insert_ready(4'd3, 1'b1);
    insert_ready(4'd1, 1'b1);
    insert_ready(4'd5, 1'b1);
    check("age_count", 32'(count), 32'd3);
    check("age_head", 32'(issue_rob_id), 32'd3);
    fu_ready = 1'b1;
    tick(); tick(); tick();
    fu_ready = 1'b0;
    check("age_drain_count", 32'(count), 32'd0);
    check("age_drain_valid", 32'(issue_valid), 32'd0);

    // Younger op reuses the lowest slot but must still issue last.
    insert_ready(4'd3, 1'b1);
    insert_ready(4'd1, 1'b1);
    fu_ready = 1'b1;
    tick();
    fu_ready = 1'b0;
    check("reuse_count1", 32'(count), 32'd1);
    insert_ready(4'd5, 1'b1);
    check("reuse_head", 32'(issue_rob_id), 32'd1);
    fu_ready = 1'b1;
    tick(); tick();
    fu_ready = 1'b0;
    check("reuse_count0", 32'(count), 32'd0);

    // Wakeup via bus 1.
    e = '{rob: 4'd2, typ: 5'd7, dj: 32'h0, dk: 32'h33, imm: 32'h44};
    set_dec(e, 1'b1, 1'b0, 4'd7, 4'd0);
    tick();
    dec_valid = 1'b0;
    e.dj = 32'hDEADBEEF;
    exp_q.push_back(e);
    check("wake_wait0", 32'(issue_valid), 32'd0);
    tick();
    cdb_valid = 2'b10;
    cdb_tag   = {4'd7, 4'd0};
    cdb_data  = {32'hDEADBEEF, 32'h0};
    check("wake_no_same_cycle", 32'(issue_valid), 32'd0);
    tick();
    cdb_valid = '0;
    check("wake_valid", 32'(issue_valid), 32'd1);
    fu_ready = 1'b1;
    tick();
    fu_ready = 1'b0;

    // Insert bypass with both buses matching: bus 0 wins.
    e = '{rob: 4'd6, typ: 5'd3, dj: 32'h55, dk: 32'h0, imm: 32'h66};
    set_dec(e, 1'b0, 1'b1, 4'd0, 4'd2);
    cdb_valid = 2'b11;
    cdb_tag   = {4'd2, 4'd2};
    cdb_data  = {32'h22, 32'h11};
    tick();
    dec_valid = 1'b0;
    cdb_valid = '0;
    e.dk = 32'h11;
    exp_q.push_back(e);
    check("bypass_valid", 32'(issue_valid), 32'd1);
    fu_ready = 1'b1;
    tick();
    fu_ready = 1'b0;
    check("bypass_count", 32'(count), 32'd0);

    // Full with simultaneous issue and held insert.
    for (int i = 0; i < DEPTH; i++) insert_ready(RW'(i), 1'b1);
    check("full_flag", 32'(dec_full), 32'd1);
    check("full_count", 32'(count), 32'd8);
    set_dec(mk_ready(4'd9), 1'b0, 1'b0, '0, '0);
    fu_ready = 1'b1;
    check("full_hold_count", 32'(count), 32'd8);
    tick();
    fu_ready = 1'b0;
    check("after_iss_count", 32'(count), 32'd7);
    check("after_iss_full", 32'(dec_full), 32'd0);
    tick();
    dec_valid = 1'b0;
    exp_q.push_back(mk_ready(4'd9));
    check("refill_count", 32'(count), 32'd8);
    check("refill_full", 32'(dec_full), 32'd1);
    fu_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    fu_ready = 1'b0;
    check("full_drain_count", 32'(count), 32'd0);

    // Stall with rdy_in low, then flush beats a concurrent insert.
    for (int i = 10; i < 14; i++) insert_ready(RW'(i), 1'b0);
    rdy_in = 1'b0;
    fu_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_count", 32'(count), 32'd4);
      check("stall_valid", 32'(issue_valid), 32'd1);
    end
    rdy_in = 1'b1;
    flush = 1'b1;
    set_dec(mk_ready(4'd14), 1'b0, 1'b0, '0, '0);
    tick();
    flush = 1'b0;
    dec_valid = 1'b0;
    fu_ready = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(issue_valid), 32'd0);

    // Asynchronous reset mid-operation.
    insert_ready(4'd1, 1'b0);
    check("pre_rst_count", 32'(count), 32'd1);
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_valid", 32'(issue_valid), 32'd0);
    tick();
    rst_in = 1'b0;
    tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
